// File: rtl/dma_copy_engine.sv
// dma_copy_engine: single-channel store-and-forward AXI4 copy engine.
// Optional host AXI pass-through mux enabled by macro DMA_HOST_MUX_EN.
package dma_pkg;
  localparam int AXI_DW = 512;
  localparam int AXI_AW = 32;
  localparam int AXI_IW = 8;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic busy;
    logic done;
  } s_dma_status_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  err_type;
    logic [31:0] addr;
  } s_dma_error_t;

  typedef struct packed {
    logic              aw_valid;
    logic [AXI_AW-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic [AXI_IW-1:0] aw_id;
    logic              w_valid;
    logic [AXI_DW-1:0] w_data;
    logic [AXI_DW/8-1:0] w_strb;
    logic              w_last;
    logic              b_ready;
    logic              ar_valid;
    logic [AXI_AW-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic [AXI_IW-1:0] ar_id;
    logic              r_ready;
  } axi_req_t;

  typedef struct packed {
    logic              aw_ready;
    logic              w_ready;
    logic              b_valid;
    logic [1:0]        b_resp;
    logic [AXI_IW-1:0] b_id;
    logic              ar_ready;
    logic              r_valid;
    logic [AXI_DW-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic [AXI_IW-1:0] r_id;
  } axi_resp_t;
endpackage

module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = AXI_DW,
  parameter int ADDR_WIDTH = AXI_AW,
  parameter int ID_WIDTH   = AXI_IW,
  parameter int BUF_BEATS  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dma_go_i,
  input  s_dma_desc_t   dma_desc_i,
  output s_dma_status_t dma_stats_o,
  output s_dma_error_t  dma_error_o,
  output axi_req_t      axi_req_o,
`ifdef DMA_HOST_MUX_EN
  input  logic          master_ctrl_i,
  input  axi_req_t      host_axi_req_i,
  output axi_resp_t     host_axi_resp_o,
`endif
  input  axi_resp_t     axi_resp_i
);

  localparam int BPB     = DATA_WIDTH / 8;
  localparam int LOG_BPB = $clog2(BPB);
  localparam int IW      = $clog2(BUF_BEATS);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD_AR,
    RD_DATA,
    WR_AW,
    WR_DATA,
    WR_RESP,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]   src_q, dst_q, rem_q;
  logic          busy_q, done_q;
  s_dma_error_t  err_q;
  logic [IW-1:0] rd_cnt_q, wr_cnt_q;

  logic [DATA_WIDTH-1:0] mem_q [BUF_BEATS];

  axi_req_t  dma_req;
  axi_resp_t dma_resp;
  logic      go_ok;

  logic [31:0] rem_beats, src_room, dst_room;
  logic [31:0] beats_c, chunk_bytes;
  logic        cfg_bad, r_err, w_last_c;
  logic        unused_ok;

`ifdef DMA_HOST_MUX_EN
  // Combinational bus ownership switch between DMA and host
  always_comb begin
    axi_req_o       = master_ctrl_i ? dma_req : host_axi_req_i;
    dma_resp        = master_ctrl_i ? axi_resp_i : '0;
    host_axi_resp_o = master_ctrl_i ? '0 : axi_resp_i;
    go_ok           = dma_go_i & master_ctrl_i;
  end
`else
  // DMA owns the master port outright
  always_comb begin
    axi_req_o = dma_req;
    dma_resp  = axi_resp_i;
    go_ok     = dma_go_i;
  end
`endif

  assign unused_ok = ^{dma_resp.b_id, dma_resp.r_id};

  // Chunk sizing: buffer depth, remaining bytes, 4 KB clip on both sides
  always_comb begin
    rem_beats = rem_q >> LOG_BPB;
    src_room  = (32'h1000 - {20'd0, src_q[11:0]}) >> LOG_BPB;
    dst_room  = (32'h1000 - {20'd0, dst_q[11:0]}) >> LOG_BPB;
    beats_c   = 32'(BUF_BEATS);
    if (rem_beats < beats_c) beats_c = rem_beats;
    if (src_room < beats_c)  beats_c = src_room;
    if (dst_room < beats_c)  beats_c = dst_room;
    chunk_bytes = beats_c << LOG_BPB;
    cfg_bad = (|src_q[LOG_BPB-1:0]) |
              (|dst_q[LOG_BPB-1:0]) |
              (|rem_q[LOG_BPB-1:0]);
    r_err    = dma_resp.r_resp != 2'b00;
    w_last_c = (32'(wr_cnt_q) + 32'd1) == beats_c;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and AXI master outputs
  always_comb begin
    state_d  = state_q;
    dma_req  = '0;
    dma_req.ar_addr  = ADDR_WIDTH'(src_q);
    dma_req.ar_len   = 8'(beats_c - 32'd1);
    dma_req.ar_size  = 3'(LOG_BPB);
    dma_req.ar_burst = 2'b01;
    dma_req.ar_id    = ID_WIDTH'(0);
    dma_req.aw_addr  = ADDR_WIDTH'(dst_q);
    dma_req.aw_len   = 8'(beats_c - 32'd1);
    dma_req.aw_size  = 3'(LOG_BPB);
    dma_req.aw_burst = 2'b01;
    dma_req.aw_id    = ID_WIDTH'(0);
    dma_req.w_data   = mem_q[wr_cnt_q];
    dma_req.w_strb   = '1;
    dma_req.w_last   = w_last_c;
    unique case (state_q)
      IDLE: begin
        if (go_ok) state_d = CHECK;
      end
      CHECK: begin
        if (cfg_bad)         state_d = IDLE;
        else if (rem_q == 0) state_d = DONE;
        else                 state_d = RD_AR;
      end
      RD_AR: begin
        dma_req.ar_valid = 1'b1;
        if (dma_resp.ar_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        dma_req.r_ready = 1'b1;
        if (dma_resp.r_valid && dma_resp.r_last) begin
          if (err_q.valid || r_err) state_d = DONE;
          else                      state_d = WR_AW;
        end
      end
      WR_AW: begin
        dma_req.aw_valid = 1'b1;
        if (dma_resp.aw_ready) state_d = WR_DATA;
      end
      WR_DATA: begin
        dma_req.w_valid = 1'b1;
        if (dma_resp.w_ready && w_last_c) state_d = WR_RESP;
      end
      WR_RESP: begin
        dma_req.b_ready = 1'b1;
        if (dma_resp.b_valid) begin
          if (dma_resp.b_resp != 2'b00) state_d = DONE;
          else if (rem_q == chunk_bytes) state_d = DONE;
          else                          state_d = RD_AR;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Descriptor, progress counters, status and error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go_ok) begin
            src_q  <= dma_desc_i.src_addr;
            dst_q  <= dma_desc_i.dst_addr;
            rem_q  <= dma_desc_i.num_bytes;
            done_q <= 1'b0;
            err_q  <= '0;
            busy_q <= 1'b1;
          end
        end
        CHECK: begin
          if (cfg_bad) begin
            err_q.valid    <= 1'b1;
            err_q.err_type <= 2'd1;
            err_q.addr     <= src_q;
            done_q         <= 1'b1;
            busy_q         <= 1'b0;
          end
        end
        RD_AR: begin
          rd_cnt_q <= '0;
          wr_cnt_q <= '0;
        end
        RD_DATA: begin
          if (dma_resp.r_valid) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (r_err && !err_q.valid) begin
              err_q.valid    <= 1'b1;
              err_q.err_type <= 2'd2;
              err_q.addr     <= src_q +
                (32'(rd_cnt_q) << LOG_BPB);
            end
          end
        end
        WR_DATA: begin
          if (dma_resp.w_ready) wr_cnt_q <= wr_cnt_q + 1'b1;
        end
        WR_RESP: begin
          if (dma_resp.b_valid) begin
            if (dma_resp.b_resp != 2'b00) begin
              err_q.valid    <= 1'b1;
              err_q.err_type <= 2'd3;
              err_q.addr     <= dst_q;
            end else begin
              src_q <= src_q + chunk_bytes;
              dst_q <= dst_q + chunk_bytes;
              rem_q <= rem_q - chunk_bytes;
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Chunk buffer fill; contents need no reset
  always_ff @(posedge clk) begin
    if (state_q == RD_DATA && dma_resp.r_valid)
      mem_q[rd_cnt_q] <= dma_resp.r_data;
  end

  assign dma_stats_o.busy = busy_q;
  assign dma_stats_o.done = done_q;
  assign dma_error_o      = err_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed bench with an AXI slave memory model.
// Sources read as an address-derived pattern; writes land in a sparse map.
module tb_dma_copy_engine;
  import dma_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  s_dma_desc_t   desc;
  s_dma_status_t stats;
  s_dma_error_t  err;
  axi_req_t      req;
  axi_resp_t     resp;

  int n_tot = 0;
  int n_pass = 0;

  logic rd_inj, wr_inj;

  logic [511:0] mem [4096];
  logic         wv  [4096];
  logic [7:0]   rd_cnt, rd_len;
  logic [31:0]  rd_addr, wr_addr;
  logic         wr_act;

  int ar_seen = 0, ar_hs = 0, aw_hs = 0, r_hs = 0;
  int ovl = 0, wlast_bad = 0, strb_bad = 0;
  logic [7:0] arlen_log [64];
  logic [7:0] aw_len_m, wb;

  always #5 clk = ~clk;

  dma_copy_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dma_go_i    (go),
    .dma_desc_i  (desc),
    .dma_stats_o (stats),
    .dma_error_o (err),
    .axi_req_o   (req),
    .axi_resp_i  (resp)
  );

  function automatic logic [11:0] idx(input logic [31:0] a);
    return {a[27:24], a[13:6]};
  endfunction

  function automatic logic [511:0] pat(input logic [31:0] a);
    logic [511:0] v;
    for (int i = 0; i < 16; i++)
      v[i*32 +: 32] = a + 32'(i) * 32'h0100_0001;
    return v;
  endfunction

  function automatic logic [511:0] mrd(input logic [31:0] a);
    return wv[idx(a)] ? mem[idx(a)] : pat(a);
  endfunction

  // AXI slave: one read and one write burst at a time
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp    <= '0;
      rd_cnt  <= '0;
      rd_len  <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_act  <= 1'b0;
      for (int i = 0; i < 4096; i++) wv[i] <= 1'b0;
    end else begin
      resp.ar_ready <= req.ar_valid && !resp.ar_ready &&
                       !resp.r_valid;
      if (req.ar_valid && resp.ar_ready) begin
        resp.r_valid <= 1'b1;
        resp.r_data  <= mrd(req.ar_addr);
        resp.r_last  <= req.ar_len == 8'd0;
        resp.r_resp  <= 2'b00;
        rd_cnt  <= 8'd0;
        rd_len  <= req.ar_len;
        rd_addr <= req.ar_addr;
      end else if (resp.r_valid && req.r_ready) begin
        if (resp.r_last) begin
          resp.r_valid <= 1'b0;
        end else begin
          rd_addr      <= rd_addr + 32'd64;
          resp.r_data  <= mrd(rd_addr + 32'd64);
          resp.r_last  <= 8'(rd_cnt + 8'd1) == rd_len;
          resp.r_resp  <= (rd_inj && rd_cnt == 8'd2) ?
                          2'b10 : 2'b00;
          rd_cnt       <= rd_cnt + 8'd1;
        end
      end
      resp.aw_ready <= req.aw_valid && !resp.aw_ready && !wr_act;
      if (req.aw_valid && resp.aw_ready) begin
        wr_act       <= 1'b1;
        wr_addr      <= req.aw_addr;
        resp.w_ready <= 1'b1;
      end else if (req.w_valid && resp.w_ready) begin
        mem[idx(wr_addr)] <= req.w_data;
        wv[idx(wr_addr)]  <= 1'b1;
        wr_addr <= wr_addr + 32'd64;
        if (req.w_last) begin
          resp.w_ready <= 1'b0;
          wr_act       <= 1'b0;
          resp.b_valid <= 1'b1;
          resp.b_resp  <= wr_inj ? 2'b10 : 2'b00;
        end
      end
      if (resp.b_valid && req.b_ready) resp.b_valid <= 1'b0;
    end
  end

  // Bus monitor: handshake counts and protocol sanity
  always @(posedge clk) begin
    if (req.ar_valid) ar_seen <= ar_seen + 1;
    if (req.ar_valid && resp.ar_ready) begin
      arlen_log[ar_hs[5:0]] <= req.ar_len;
      ar_hs <= ar_hs + 1;
    end
    if (resp.r_valid && req.r_ready) r_hs <= r_hs + 1;
    if (req.aw_valid && resp.aw_ready) begin
      aw_hs    <= aw_hs + 1;
      aw_len_m <= req.aw_len;
      wb       <= 8'd0;
    end
    if (req.w_valid && resp.w_ready) begin
      if (req.w_last !== (wb == aw_len_m))
        wlast_bad <= wlast_bad + 1;
      if (req.w_strb !== '1) strb_bad <= strb_bad + 1;
      wb <= wb + 8'd1;
    end
    if ((req.ar_valid || req.r_ready) &&
        (req.aw_valid || req.w_valid || req.b_ready))
      ovl <= ovl + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input logic [31:0] s,
                     input logic [31:0] d,
                     input logic [31:0] n);
    @(negedge clk);
    desc.src_addr  = s;
    desc.dst_addr  = d;
    desc.num_bytes = n;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!stats.done && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 64'(stats.done), 64'd1);
    chk({tag, "_busy"}, 64'(stats.busy), 64'd0);
  endtask

  task automatic data_bad(input logic [31:0] s,
                          input logic [31:0] d,
                          input int beats,
                          output int bad);
    bad = 0;
    for (int i = 0; i < beats; i++) begin
      logic [31:0] off;
      off = 32'(i) * 32'd64;
      if (!wv[idx(d + off)] || mem[idx(d + off)] !== pat(s + off))
        bad++;
    end
  endtask

  int b0, b1, b2, b3, b4, b5;
  logic [63:0] exp_err;

  initial begin
    rst_n = 1'b0;
    go = 1'b0;
    desc = '0;
    rd_inj = 1'b0;
    wr_inj = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_stats", 64'(stats), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_axi", 64'({req.ar_valid, req.aw_valid,
        req.w_valid, req.r_ready, req.b_ready}), 64'd0);

    b0 = ar_hs; b1 = aw_hs;
    run(32'h1100_0000, 32'h1200_0000, 32'h800);
    wait_done("t1_done");
    chk("t1_err", 64'(err.valid), 64'd0);
    chk("t1_ar_cnt", 64'(ar_hs - b0), 64'd2);
    chk("t1_aw_cnt", 64'(aw_hs - b1), 64'd2);
    chk("t1_arlen0", 64'(arlen_log[b0[5:0]]), 64'd15);
    chk("t1_arlen1", 64'(arlen_log[6'(b0 + 1)]), 64'd15);
    data_bad(32'h1100_0000, 32'h1200_0000, 32, b2);
    chk("t1_data", 64'(b2), 64'd0);

    run(32'h1300_0000, 32'h1400_0000, 32'h800);
    chk("t2_done_clr", 64'(stats), 64'b10);
    wait_done("t2_done");
    data_bad(32'h1300_0000, 32'h1400_0000, 32, b2);
    chk("t2_data", 64'(b2), 64'd0);
    data_bad(32'h1100_0000, 32'h1200_0000, 32, b2);
    chk("t2_data_old", 64'(b2), 64'd0);

    b0 = ar_hs;
    run(32'h1100_0FC0, 32'h1500_0000, 32'h100);
    wait_done("t3_done");
    chk("t3_ar_cnt", 64'(ar_hs - b0), 64'd2);
    chk("t3_arlen0", 64'(arlen_log[b0[5:0]]), 64'd0);
    chk("t3_arlen1", 64'(arlen_log[6'(b0 + 1)]), 64'd2);
    data_bad(32'h1100_0FC0, 32'h1500_0000, 4, b2);
    chk("t3_data", 64'(b2), 64'd0);

    b0 = ar_seen;
    run(32'h1100_0004, 32'h1200_0000, 32'h800);
    wait_done("t4_done");
    exp_err = {29'd0, 1'b1, 2'd1, 32'h1100_0004};
    chk("t4_err", 64'(err), exp_err);
    chk("t4_no_ar", 64'(ar_seen - b0), 64'd0);

    run(32'h1100_0000, 32'h1200_0000, 32'h50);
    wait_done("t4b_done");
    exp_err = {29'd0, 1'b1, 2'd1, 32'h1100_0000};
    chk("t4b_err", 64'(err), exp_err);

    b0 = ar_seen;
    run(32'h1100_0000, 32'h1A00_0000, 32'h0);
    wait_done("t4c_done");
    chk("t4c_err", 64'(err.valid), 64'd0);
    chk("t4c_no_ar", 64'(ar_seen - b0), 64'd0);

    rd_inj = 1'b1;
    b0 = ar_hs; b1 = aw_hs; b3 = r_hs;
    run(32'h1100_0000, 32'h1600_0000, 32'h800);
    wait_done("t5_done");
    rd_inj = 1'b0;
    exp_err = {29'd0, 1'b1, 2'd2, 32'h1100_00C0};
    chk("t5_err", 64'(err), exp_err);
    chk("t5_r_drain", 64'(r_hs - b3), 64'd16);
    chk("t5_ar_cnt", 64'(ar_hs - b0), 64'd1);
    chk("t5_no_aw", 64'(aw_hs - b1), 64'd0);

    wr_inj = 1'b1;
    b1 = aw_hs;
    run(32'h1100_0000, 32'h1700_0000, 32'h800);
    wait_done("t5b_done");
    wr_inj = 1'b0;
    exp_err = {29'd0, 1'b1, 2'd3, 32'h1700_0000};
    chk("t5b_err", 64'(err), exp_err);
    chk("t5b_aw_cnt", 64'(aw_hs - b1), 64'd1);

    run(32'h1100_0000, 32'h1800_0000, 32'h800);
    b4 = 0;
    while (!req.w_valid && b4 < 200) begin
      @(negedge clk);
      b4++;
    end
    chk("t6_in_wdata", 64'(req.w_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_axi", 64'({req.ar_valid, req.aw_valid,
        req.w_valid, req.r_ready, req.b_ready}), 64'd0);
    chk("t6_rst_stats", 64'(stats), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b5 = aw_hs;
    repeat (3) @(negedge clk);
    chk("t6_idle", 64'({req.aw_valid, req.w_valid,
        64'(aw_hs - b5) != 64'd0}), 64'd0);
    run(32'h1300_0000, 32'h1900_0000, 32'h400);
    wait_done("t6_done");
    chk("t6_err", 64'(err.valid), 64'd0);
    data_bad(32'h1300_0000, 32'h1900_0000, 16, b2);
    chk("t6_data", 64'(b2), 64'd0);

    chk("overlap", 64'(ovl), 64'd0);
    chk("wlast", 64'(wlast_bad), 64'd0);
    chk("wstrb", 64'(strb_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Single-channel memory-to-memory DMA copy engine with one AXI4 master port.
- Software supplies a descriptor (src_addr, dst_addr, num_bytes) and pulses go.
- The engine copies data in store-and-forward chunks: an INCR read burst into an internal buffer, then an INCR write burst from it.
- Sits between the CSR block and the system AXI interconnect, and reports done and error status.

Parameters:
- DATA_WIDTH, 512, AXI data width in bits; BPB = DATA_WIDTH/8 bytes per beat.
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 8, AXI ID width; all IDs driven 0.
- BUF_BEATS, 16, internal buffer depth in beats; maximum burst length.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- dma_go_i  in  1  start pulse, sampled only in IDLE.
- dma_desc_i  in  s_dma_desc_t  {src_addr[31:0], dst_addr[31:0], num_bytes[31:0]}.
- dma_stats_o  out  s_dma_status_t  {busy, done}.
- dma_error_o  out  s_dma_error_t  {valid, type[1:0] (0 none, 1 config, 2 read resp, 3 write resp), addr[31:0]}.
- axi_req_o  out  axi_req_t  AW/W/B-ready/AR/R-ready master signals.
- axi_resp_i  in  axi_resp_t  slave responses.

Behaviour:
- Reset (async, immediate): state IDLE; all AXI valids/readies 0; busy=0, done=0; error cleared. Reset mid-transfer abandons the transfer with no further handshakes.
- IDLE: on dma_go_i=1, latch descriptor, clear done and error, set busy. dma_go_i while busy is ignored.
- Config check, first cycle after go:
  - src or dst not BPB-aligned, or num_bytes not a multiple of BPB → error type 1, addr=src, done=1, busy=0, no AXI traffic.
  - num_bytes==0 → done=1 the next cycle, no traffic.
- Chunk size: beats = min(remaining/BPB, BUF_BEATS), further clipped so neither the src nor the dst burst crosses a 4 KB boundary.
- RD_AR: arvalid=1, araddr=src, arlen=beats-1, arsize=log2(BPB), arburst=INCR, arid=0. Signals held stable until arready.
- RD_DATA: rready=1; beats written to the buffer in order; leave on rvalid&rlast. rresp≠OKAY → record error type 2 with the beat address, but still drain to rlast.
- WR_AW: awvalid=1, awaddr=dst, same len/size/burst. Hold until awready.
- WR_DATA: wvalid=1, wstrb all ones, wdata from buffer in order, wlast on beat beats-1. Advance only on wready.
- WR_RESP: bready=1; on bvalid, bresp≠OKAY → error type 3, addr=dst.
- After each chunk: src+=beats*BPB, dst+=beats*BPB, remaining-=beats*BPB.
  - Error recorded → DONE.
  - remaining==0 → DONE.
  - Otherwise → RD_AR.
- DONE: done=1, busy=0, return to IDLE. done stays high until the next accepted go.
- Error fields hold until the next accepted go.
- Only one outstanding burst at any time; read and write never overlap.

Optional Feature:
- Macro DMA_HOST_MUX_EN.
- When defined, add these ports:
  - master_ctrl_i (1 bit).
  - host_axi_req_i (axi_req_t).
  - host_axi_resp_o (axi_resp_t).
- Behaviour with the macro defined:
  - axi_req_o is driven by the DMA when master_ctrl_i=1, otherwise by the host (purely combinational).
  - axi_resp_i is routed to the selected side; the unselected side sees all valids and readies 0.
  - go is ignored while master_ctrl_i=0.
- When undefined, the DMA drives axi_req_o directly.

Test Plan:
- Preload 2048 B at 0x1100_0000; desc {0x1100_0000, 0x1200_0000, 0x800}; go → two 16-beat read and write burst pairs (arlen=15), done=1. Readback at 0x1200_0000 matches the source pattern.
- Second descriptor {0x1300_0000, 0x1400_0000, 0x800} after completion → done clears on go, then reasserts; both destination regions are correct.
- Source 0x1100_0FC0, num_bytes 0x100 → first burst 1 beat (4 KB clip), then 3 beats; data correct.
- src=0x1100_0004 → error valid, type 1, addr 0x1100_0004, done=1, no arvalid ever.
- Slave returns SLVERR on beat 3 of the first read → drains to rlast, error type 2, done=1, no AW issued.
- Assert rst_n low during WR_DATA → outputs return to reset values immediately; a new go then completes normally.
